// File: rtl/shift_pkg.sv
// Shared constants and helpers for the pipelined shifter/rotator.
package shift_pkg;

  // Operation encodings carried on the mode port and through the pipeline.
  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  // Widest operand the bit-reverse helper can handle.
  localparam int MAX_WIDTH = 256;

  // Pipeline depth: number of radix digits needed to cover the shift amount.
  function automatic int calc_stages(input int width, input int radix_bits);
    int shw;
    shw = $clog2(width);
    return (shw + radix_bits - 1) / radix_bits;
  endfunction

  // Reverse the low 'width' bits of v; bits above 'width' come back as zero.
  function automatic logic [MAX_WIDTH-1:0] bit_reverse(input logic [MAX_WIDTH-1:0] v,
                                                        input int width);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) r[i] = v[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One radix stage of the shifter: a 2^RADIX_BITS:1 mux whose legs are
// constant left-shifts (with fill) or constant rotates of the operand.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH      = 13,
  parameter int RADIX_BITS = 2,
  parameter int STAGE_IDX  = 0
) (
  input  logic [WIDTH-1:0]      data_i,
  input  logic [RADIX_BITS-1:0] digit_i,
  input  logic [1:0]            mode_i,
  input  logic                  fill_i,
  output logic [WIDTH-1:0]      data_o
);

  localparam int NLEGS = 2 ** RADIX_BITS;

  logic [WIDTH-1:0] leg [NLEGS];

  for (genvar gi = 0; gi < NLEGS; gi++) begin : g_leg
    // Weight of this digit value at this stage's position.
    localparam longint AMT = longint'(gi) <<< (STAGE_IDX * RADIX_BITS);
    // Shift amounts at or beyond WIDTH saturate to all-fill.
    localparam int SHL = (AMT >= longint'(WIDTH)) ? WIDTH : int'(AMT);
    localparam int ROT = int'(AMT % longint'(WIDTH));

    logic [WIDTH-1:0] shl_leg;
    logic [WIDTH-1:0] rol_leg;

    if (SHL >= WIDTH) begin : g_shl_full
      assign shl_leg = {WIDTH{fill_i}};
    end else if (SHL == 0) begin : g_shl_none
      assign shl_leg = data_i;
    end else begin : g_shl_part
      assign shl_leg = {data_i[WIDTH-1-SHL:0], {SHL{fill_i}}};
    end

    if (ROT == 0) begin : g_rol_none
      assign rol_leg = data_i;
    end else begin : g_rol_part
      assign rol_leg = {data_i[WIDTH-1-ROT:0], data_i[WIDTH-1:WIDTH-ROT]};
    end

    assign leg[gi] = (mode_i == MODE_ROL) ? rol_leg : shl_leg;
  end

  assign data_o = leg[digit_i];

endmodule

// File: rtl/shift_rotate_pipelined.sv
// Pipelined barrel shifter/rotator with valid/ready handshake and sideband tag.
// Right modes are bit-reversed around a left-shifting core; ROL amounts are
// reduced mod WIDTH before the first stage. All stages stall together.
module shift_rotate_pipelined
  import shift_pkg::*;
#(
  parameter int  WIDTH      = 13,
  parameter int  RADIX_BITS = 2,
  parameter int  TAG_WIDTH  = 4,
  localparam int SHW        = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in,
  input  logic [SHW-1:0]       shift,
  input  logic [1:0]           mode,
  input  logic [TAG_WIDTH-1:0] tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out,
  output logic [TAG_WIDTH-1:0] out_tag
);

  localparam int STAGES = calc_stages(WIDTH, RADIX_BITS);
  localparam int PADW   = STAGES * RADIX_BITS;
  localparam int LAST   = STAGES - 1;

  // Global advance: the whole pipe moves or the whole pipe holds.
  logic adv;

  // Entry-side conditioned operand and sideband.
  logic             entry_right;
  logic             entry_fill;
  logic [SHW-1:0]   entry_shift;
  logic [PADW-1:0]  entry_shift_pad;
  logic [WIDTH-1:0] entry_data;

  // Per-stage register inputs (_d) and registers (_q).
  logic [WIDTH-1:0]     stage_in [STAGES];
  logic [WIDTH-1:0]     data_d   [STAGES];
  logic [PADW-1:0]      shift_d  [STAGES];
  logic [1:0]           mode_d   [STAGES];
  logic                 fill_d   [STAGES];
  logic [TAG_WIDTH-1:0] tag_d    [STAGES];
  logic                 valid_d  [STAGES];

  logic [WIDTH-1:0]     data_q   [STAGES];
  logic [PADW-1:0]      shift_q  [STAGES];
  logic [1:0]           mode_q   [STAGES];
  logic                 fill_q   [STAGES];
  logic [TAG_WIDTH-1:0] tag_q    [STAGES];
  logic                 valid_q  [STAGES];

  assign out_valid = valid_q[LAST];
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;

  // Entry conditioning: ROL mod-WIDTH reduction, right-mode reversal, ASR fill.
  always_comb begin
    entry_right = (mode == MODE_LSR) || (mode == MODE_ASR);
    entry_fill  = (mode == MODE_ASR) && in[WIDTH-1];
    entry_shift = shift;
    // shift < 2*WIDTH always, so one conditional subtract gives shift mod WIDTH.
    if ((mode == MODE_ROL) && ({1'b0, shift} >= (SHW+1)'(WIDTH))) begin
      entry_shift = shift - SHW'(WIDTH);
    end
    entry_shift_pad = PADW'(entry_shift);
    entry_data      = entry_right ? WIDTH'(bit_reverse(MAX_WIDTH'(in), WIDTH)) : in;
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      assign stage_in[gi]   = entry_data;
      assign shift_d[gi]    = entry_shift_pad;
      assign mode_d[gi]     = mode;
      assign fill_d[gi]     = entry_fill;
      assign tag_d[gi]      = tag;
      assign valid_d[gi]    = in_valid & adv;
    end else begin : g_next
      assign stage_in[gi]   = data_q[gi-1];
      assign shift_d[gi]    = shift_q[gi-1];
      assign mode_d[gi]     = mode_q[gi-1];
      assign fill_d[gi]     = fill_q[gi-1];
      assign tag_d[gi]      = tag_q[gi-1];
      assign valid_d[gi]    = valid_q[gi-1];
    end

    shift_stage #(
      .WIDTH      (WIDTH),
      .RADIX_BITS (RADIX_BITS),
      .STAGE_IDX  (gi)
    ) u_stage (
      .data_i  (stage_in[gi]),
      .digit_i (shift_d[gi][gi*RADIX_BITS +: RADIX_BITS]),
      .mode_i  (mode_d[gi]),
      .fill_i  (fill_d[gi]),
      .data_o  (data_d[gi])
    );
  end

  // Pipeline registers: cleared on reset, loaded together on every advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < STAGES; s++) begin
        data_q[s]  <= '0;
        shift_q[s] <= '0;
        mode_q[s]  <= '0;
        fill_q[s]  <= 1'b0;
        tag_q[s]   <= '0;
        valid_q[s] <= 1'b0;
      end
    end else if (adv) begin
      for (int s = 0; s < STAGES; s++) begin
        data_q[s]  <= data_d[s];
        shift_q[s] <= shift_d[s];
        mode_q[s]  <= mode_d[s];
        fill_q[s]  <= fill_d[s];
        tag_q[s]   <= tag_d[s];
        valid_q[s] <= valid_d[s];
      end
    end
  end

  // Exit: undo the entry reversal for right modes.
  always_comb begin
    out_tag = tag_q[LAST];
    out     = data_q[LAST];
    if ((mode_q[LAST] == MODE_LSR) || (mode_q[LAST] == MODE_ASR)) begin
      out = WIDTH'(bit_reverse(MAX_WIDTH'(data_q[LAST]), WIDTH));
    end
  end

endmodule
